// File: rtl/instr_decode.sv
// Decode stage: IF/ID pipeline register, 32x32 register file, main control, immediate
// extension and load-use hazard detection. Define ID_REGFILE_BYPASS_EN for write-before-read.
module instr_decode (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_next_in,
  input  logic [31:0] instruction_in,
  input  logic        flush,
  input  logic        id_ex_mem_read,
  input  logic [4:0]  id_ex_rt,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_write_reg,
  input  logic [31:0] wb_write_data,
  output logic [31:0] pc_next_out,
  output logic [31:0] read_data1,
  output logic [31:0] read_data2,
  output logic [31:0] imm_ext,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic        reg_dst,
  output logic        alu_src,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        branch,
  output logic [1:0]  alu_op,
  output logic        stall
);

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;

  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic [31:0] regs_q [32];
  logic [5:0]  opcode;
  logic        is_rtype;
  logic        rt_is_src;
  // {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op[1:0]}
  logic [8:0]  ctrl;

  // IF/ID register: flush beats stall so a squashed slot always becomes a NOP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q <= '0;
      pc_q    <= '0;
    end else if (flush) begin
      instr_q <= '0;
      pc_q    <= '0;
    end else if (!stall) begin
      instr_q <= instruction_in;
      pc_q    <= pc_next_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_reg_write && (wb_write_reg != 5'd0)) begin
      regs_q[wb_write_reg] <= wb_write_data;
    end
  end

  assign opcode      = instr_q[31:26];
  assign rs          = instr_q[25:21];
  assign rt          = instr_q[20:16];
  assign rd          = instr_q[15:11];
  assign imm_ext     = {{16{instr_q[15]}}, instr_q[15:0]};
  assign pc_next_out = pc_q;

  always_comb begin
    read_data1 = (rs == 5'd0) ? 32'd0 : regs_q[rs];
    read_data2 = (rt == 5'd0) ? 32'd0 : regs_q[rt];
`ifdef ID_REGFILE_BYPASS_EN
    if (wb_reg_write && (wb_write_reg != 5'd0) && (wb_write_reg == rs)) begin
      read_data1 = wb_write_data;
    end
    if (wb_reg_write && (wb_write_reg != 5'd0) && (wb_write_reg == rt)) begin
      read_data2 = wb_write_data;
    end
`endif
  end

  assign is_rtype  = (opcode == OpRtype) && (instr_q != 32'd0);
  assign rt_is_src = is_rtype || (opcode == OpSw) || (opcode == OpBeq);

  assign stall = id_ex_mem_read && (id_ex_rt != 5'd0) &&
                 ((id_ex_rt == rs) || ((id_ex_rt == rt) && rt_is_src));

  always_comb begin
    ctrl = 9'b0;
    case (opcode)
      OpRtype: if (is_rtype) ctrl = 9'b1_0_0_1_0_0_0_10;
      OpLw:    ctrl = 9'b0_1_1_1_1_0_0_00;
      OpSw:    ctrl = 9'b0_1_0_0_0_1_0_00;
      OpBeq:   ctrl = 9'b0_0_0_0_0_0_1_01;
      OpAddi:  ctrl = 9'b0_1_0_1_0_0_0_00;
      default: ctrl = 9'b0;
    endcase
    // Bubble into ID/EX while the load-use hazard holds.
    if (stall) begin
      ctrl = 9'b0;
    end
  end

  assign {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op} = ctrl;

endmodule

// File: doc/instr_decode.md
# instr_decode

Decode stage of the 5-stage pipelined datapath, directly downstream of instruction fetch. It holds the IF/ID pipeline register and the 32×32 register file, and generates main control and the sign-extended immediate. It also detects load-use hazards and drives `stall` back to the fetch stage's program-counter enable. Outputs feed the ID/EX register combinationally.

## Interface
- No parameters. Widths are fixed: 32-bit datapath, 5-bit register indices.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high; clears IF/ID and the register file.
- `pc_next_in`  in  32  pc+4 from fetch.
- `instruction_in`  in  32  instruction from fetch.
- `flush`  in  1  branch taken (mem-stage `pc_source`); squashes IF/ID.
- `id_ex_mem_read`  in  1  instruction currently in EX is a load.
- `id_ex_rt`  in  5  destination register of that load.
- `wb_reg_write`  in  1  write-back enable.
- `wb_write_reg`  in  5  write-back register index.
- `wb_write_data`  in  32  write-back data.
- `pc_next_out`  out  32  latched pc+4.
- `read_data1`, `read_data2`  out  32  contents of rs and rt.
- `imm_ext`  out  32  sign-extended instr[15:0].
- `rs`, `rt`, `rd`  out  5 each  instr[25:21], [20:16], [15:11].
- `reg_dst`, `alu_src`, `mem_to_reg`, `reg_write`, `mem_read`, `mem_write`, `branch`  out  1 each  control signals.
- `alu_op`  out  2  ALU control class.
- `stall`  out  1  hold PC and IF/ID; active-high.

## Operation
- **IF/ID register.** Priority on each rising edge: reset, then flush, then stall, then load.
  - flush: instr ← 0x00000000, pc ← 0.
  - stall: hold.
  - otherwise: capture `instruction_in` and `pc_next_in`.
- **Decode.** Decoding uses the latched instruction.
  - All-zero word is a NOP: all controls 0.
  - R-type (opcode 0x00, nonzero word): reg_dst=1, reg_write=1, alu_op=10.
  - lw (0x23): alu_src=1, mem_to_reg=1, reg_write=1, mem_read=1, alu_op=00.
  - sw (0x2B): alu_src=1, mem_write=1, alu_op=00.
  - beq (0x04): branch=1, alu_op=01.
  - addi (0x08): alu_src=1, reg_write=1, alu_op=00.
  - Any other opcode: all controls 0.
- **Register file.**
  - Two asynchronous read ports, one write port written on the rising edge when `wb_reg_write`=1.
  - r0 reads 0 always; writes to r0 are ignored.
- **Load-use hazard.** `stall` = id_ex_mem_read & (id_ex_rt≠0) & ((id_ex_rt==rs) | (id_ex_rt==rt & rt is a source)).
  - rt is a source for R-type, sw and beq only.
  - While `stall`=1, all control outputs are forced to 0 (bubble). Data and index outputs are unaffected.
- `flush` and `stall` in the same cycle: flush wins, and the IF/ID register loads the NOP.

## Timing
- **Reset values.**
  - IF/ID instr=0, pc=0, so `pc_next_out`=0 and all controls 0.
  - All registers 0, so `read_data1`=`read_data2`=0 and `imm_ext`=0.
  - `stall`=0 unless the EX inputs trigger it.
- Reset mid-operation clears state immediately, independent of `clk`.
- Latency: an instruction presented in cycle n appears decoded on the outputs during cycle n+1. Decode and register-file read are combinational after the IF/ID register.
- `stall` is combinational in the same cycle; fetch must sample it before the next edge.
- Register write takes effect at the edge. Without bypass, a read in the same cycle as a write returns the old value.

## Configuration
- `ID_REGFILE_BYPASS_EN`
  - Defined: if `wb_reg_write`=1, `wb_write_reg`≠0 and it equals rs or rt, the corresponding read port returns `wb_write_data` in that cycle (write-before-read).
  - Undefined: no bypass; the read returns stored contents, and software must separate a write-back from a dependent read by one instruction.

## Test plan
- **Reset.** Assert reset mid-run → all outputs 0, registers r1..r31 read 0; after release, the first captured instruction decodes in the next cycle.
- **Write then decode.** Write r5=0x0000_1234 via WB, then feed lw r8,-4(r5) (0x8CA8FFFC) → read_data1=0x1234, imm_ext=0xFFFFFFFC, rt=8, mem_read=1, mem_to_reg=1, alu_src=1, reg_write=1, alu_op=00.
- **Load-use.** id_ex_mem_read=1, id_ex_rt=8, IF/ID holds add r9,r8,r2 → stall=1, controls 0, IF/ID unchanged after the edge. Same with id_ex_rt=0 → stall=0.
- **Flush.** flush=1 together with stall=1 → IF/ID becomes 0x00000000 and controls 0 next cycle.
- **Bypass.** wb_reg_write=1, wb_write_reg=3, data 0xDEADBEEF, decoding rs=3:
  - with `ID_REGFILE_BYPASS_EN` defined → read_data1=0xDEADBEEF in the same cycle;
  - without it → old value.
- **r0 and unknown opcodes.** WB to r0 with 0xFFFFFFFF → reads remain 0. Opcode 0x3F → all controls 0.
